dmem_responder: RTL and testbench

Data-memory responder serving the core's load/store requests over a valid/ready request channel and a valid/ready response channel. It is the slave end of the datapath's memory interface and replaces the combinational PMEM path once the core moves to a multi-cycle memory protocol. It holds a word-organised register array, decodes RV32 funct3 sub-word sizes, applies store byte lanes, sign/zero-extends loads, and models a fixed access latency.

---
 rtl/dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the core's load/store port. It accepts one access
// at a time over a valid/ready request channel and returns the result over a
// valid/ready response channel after a fixed latency. Storage is a
// word-organised register array (contents are not reset). Stores use RV32
// sub-word byte lanes and loads are sign- or zero-extended as funct3 selects.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The request side holds req_valid and the
// request fields stable until that edge. The responder holds resp_valid,
// resp_rdata and resp_err stable until the response transfers.
//
// Optional feature macro: DMEM_ACCESS_CHK_EN
//   defined   : out-of-range, misaligned or illegal-funct3 accesses set
//               resp_err. An erroring store writes nothing and an erroring
//               load returns 0.
//   undefined : resp_err is tied 0. The index wraps modulo the depth,
//               misaligned halves/words are forced to natural alignment and
//               an illegal funct3 is treated as a word access.
//
// Parameters
//   ADDR_W   byte-address bits mapped into the array (depth 2^(ADDR_W-2))
//   BASE     byte address of word 0 (word aligned)
//   LATENCY  accept-to-response latency, legal range 1..15
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder idle, can accept
//   req_wen     in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data, right-aligned
//   req_funct3  in   RV32 funct3 of the load/store
//   resp_valid  out  response present
//   resp_ready  in   core accepts response
//   resp_rdata  out  extended load data, 0 for stores
//   resp_err    out  access fault
//   dbg_state   out  current FSM state (0 idle, 1 wait, 2 resp)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    // With a single-cycle latency the access commits on the accept edge itself.
    localparam bit         DIRECT   = (LATENCY <= 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        req_ready_q;
    logic        resp_valid_q;

    // Request fields captured on the accept edge.
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;

    logic [31:0] mem [DEPTH];

    // -------------------------------------------------------------------------
    // Access selection: the commit edge is either the accept edge (DIRECT) or
    // the last WAIT edge. In the first case the fields come straight from the
    // request port, otherwise from the captured copy.
    // -------------------------------------------------------------------------
    logic        acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_funct3;
    logic        commit;

    always_comb begin
        if (state == ST_IDLE) begin
            acc_wen    = req_wen;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end else begin
            acc_wen    = lat_wen;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
            acc_funct3 = lat_funct3;
        end
    end

    assign commit = (DIRECT && (state == ST_IDLE) && req_valid)
                 || ((state == ST_WAIT) && (cnt == 4'd1));

    // -------------------------------------------------------------------------
    // Decode: size, signedness and legality from funct3.
    // -------------------------------------------------------------------------
    logic [31:0]       off;
    logic [ADDR_W-3:0] idx;
    logic              sz_byte;
    logic              sz_half;
    logic              sz_word;
    logic              ld_signed;
    logic              acc_legal;
    logic              acc_err;

    assign off = acc_addr - BASE;
    assign idx = off[ADDR_W-1:2];

    always_comb begin
        sz_byte   = 1'b0;
        sz_half   = 1'b0;
        ld_signed = 1'b0;
        acc_legal = 1'b1;
        if (acc_wen) begin
            case (acc_funct3)
                3'b000:  sz_byte = 1'b1;
                3'b001:  sz_half = 1'b1;
                3'b010:  ;
                default: acc_legal = 1'b0;
            endcase
        end else begin
            case (acc_funct3)
                3'b000: begin sz_byte = 1'b1; ld_signed = 1'b1; end
                3'b001: begin sz_half = 1'b1; ld_signed = 1'b1; end
                3'b010:  ;
                3'b100:  sz_byte = 1'b1;
                3'b101:  sz_half = 1'b1;
                default: acc_legal = 1'b0;
            endcase
        end
    end

    // Anything that is neither byte nor half (including illegal codes) is a word.
    assign sz_word = !sz_byte && !sz_half;

    logic unused_bits;

`ifdef DMEM_ACCESS_CHK_EN
    assign acc_err = !acc_legal
                  || ((off >> ADDR_W) != 32'd0)
                  || (sz_half && acc_addr[0])
                  || (sz_word && (acc_addr[1:0] != 2'b00));
    assign unused_bits = ^off[1:0];
`else
    assign acc_err = 1'b0;
    assign unused_bits = ^{acc_legal, off[31:ADDR_W], off[1:0]};
`endif

    // -------------------------------------------------------------------------
    // Load path: pick the lane and extend.
    // -------------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign rd_word = mem[idx];

    always_comb begin
        case (acc_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    // Address bit 0 is ignored for halves: misaligned halves fall back to the
    // naturally aligned half (they are flagged instead when checking is on).
    assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        if (sz_byte) begin
            load_data = {{24{ld_signed & rd_byte[7]}}, rd_byte};
        end else if (sz_half) begin
            load_data = {{16{ld_signed & rd_half[15]}}, rd_half};
        end else begin
            load_data = rd_word;
        end
    end

    // -------------------------------------------------------------------------
    // Store path: replicate the right-aligned data across lanes and enable
    // only the lanes being written.
    // -------------------------------------------------------------------------
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_en;

    always_comb begin
        if (sz_byte) begin
            wr_data = {4{acc_wdata[7:0]}};
            wr_be   = 4'b0001 << acc_addr[1:0];
        end else if (sz_half) begin
            wr_data = {2{acc_wdata[15:0]}};
            wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            wr_data = acc_wdata;
            wr_be   = 4'b1111;
        end
    end

    assign wr_en = commit && acc_wen && !acc_err;

    // Array has no reset; a reset during WAIT never reaches a commit edge, so a
    // dropped store leaves the array untouched.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake outputs and response data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            lat_wen      <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_funct3   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_wen     <= req_wen;
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        lat_funct3  <= req_funct3;
                        cnt         <= CNT_INIT;
                        req_ready_q <= 1'b0;
                        if (DIRECT) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state        <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state        <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase

            // Response data is captured once, on the commit edge, and then
            // held through the whole RESP state.
            if (commit) begin
                resp_rdata <= (acc_wen || acc_err) ? 32'd0 : load_data;
                resp_err   <= acc_err;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          LAT    = 2;
`ifdef DMEM_ACCESS_CHK_EN
    localparam bit          CHK    = 1'b1;
`else
    localparam bit          CHK    = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (LATENCY=2) ----------------
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    dmem_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    // ---------------- single-cycle DUT (LATENCY=1) ----------------
    logic        f_req_valid, f_req_ready, f_req_wen;
    logic [31:0] f_req_addr, f_req_wdata;
    logic [2:0]  f_req_funct3;
    logic        f_resp_valid, f_resp_ready, f_resp_err;
    logic [31:0] f_resp_rdata;
    logic [1:0]  f_dbg_state;

    dmem_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .LATENCY(1)) u_fast (
        .clk(clk), .rst(rst),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wen(f_req_wen),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_funct3(f_req_funct3),
        .resp_valid(f_resp_valid), .resp_ready(f_resp_ready),
        .resp_rdata(f_resp_rdata), .resp_err(f_resp_err), .dbg_state(f_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests;
    int fails;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a flat byte memory addressed by offset from BASE.
    logic [7:0] ref_mem [0:(1<<ADDR_W)-1];

    // Returns {err, rdata}; stores update ref_mem.
    function automatic logic [32:0] ref_access(input logic wen, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [2:0] f3);
        logic [31:0] off;
        logic [31:0] v;
        int size;
        int b0;
        bit sgn;
        bit legal;
        bit err;
        off = addr - BASE;
        sgn = 1'b0;
        if (wen) begin
            legal = (f3 inside {3'd0, 3'd1, 3'd2});
            size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        end else begin
            legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
            sgn   = (f3 == 3'd0 || f3 == 3'd1);
        end
        err = CHK && (!legal || (off >= (32'd1 << ADDR_W))
                      || (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
        if (err) return {1'b1, 32'h0};
        b0 = (int'(off[ADDR_W-1:0]) / size) * size;
        if (wen) begin
            for (int i = 0; i < size; i++) ref_mem[b0 + i] = wdata[8*i +: 8];
            return 33'h0;
        end
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[b0 + i];
        if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
        else if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
        return {1'b0, v};
    endfunction

    // ---------------- driver ----------------
    // Entered and left just after a falling edge, with resp_ready high.
    task automatic do_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, input string tag,
                             output logic [31:0] rdata, output logic err);
        logic [32:0] exp;
        int edges;
        exp = ref_access(wen, addr, wdata, f3);
        exp_q.push_back(exp[31:0]);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        req_valid = 1'b1;
        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        edges = 1;
        while (resp_valid !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "/latency"}, 32'(edges), 32'(LAT));
        rdata = resp_rdata;
        err   = resp_err;
        check({tag, "/rdata"}, rdata, exp_q.pop_front());
        check({tag, "/err"}, 32'(err), 32'(exp[32]));
        @(negedge clk);
        check({tag, "/resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin : stim
        logic [31:0] rd, stall_data, word0;
        logic        er;
        logic [32:0] e1, e2;
        int          n, nvalid;

        tests = 0; fails = 0;
        rst = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        resp_ready = 1'b1;
        f_req_valid = 1'b0; f_req_wen = 1'b0; f_req_addr = '0; f_req_wdata = '0;
        f_req_funct3 = '0; f_resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/resp_valid", 32'(resp_valid), 32'd0);
        check("rst/rdata", resp_rdata, 32'd0);
        check("rst/err", 32'(resp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst/req_ready", 32'(req_ready), 32'd1);

        // Fill the first 16 words and the last word with known data.
        for (int w = 0; w < 16; w++) do_access(1'b1, BASE + 32'(w*4), $urandom, 3'b010, "init", rd, er);
        do_access(1'b1, BASE + 32'hFFC, 32'hA5A5_5A5A, 3'b010, "init_last", rd, er);

        // Store then load the same word.
        do_access(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 3'b010, "sw_dead", rd, er);
        check("sw_dead/zero", rd, 32'h0);
        do_access(1'b0, BASE + 32'h10, 32'h0, 3'b010, "lw_dead", rd, er);
        check("lw_dead/lit", rd, 32'hDEAD_BEEF);

        // Sub-word store and loads.
        do_access(1'b1, BASE + 32'h11, 32'h0000_007F, 3'b000, "sb", rd, er);
        do_access(1'b0, BASE + 32'h10, 32'h0, 3'b010, "lw_sb", rd, er);
        check("lw_sb/lit", rd, 32'hDEAD_7FEF);
        do_access(1'b0, BASE + 32'h13, 32'h0, 3'b000, "lb", rd, er);
        check("lb/lit", rd, 32'hFFFF_FFDE);
        do_access(1'b0, BASE + 32'h13, 32'h0, 3'b100, "lbu", rd, er);
        check("lbu/lit", rd, 32'h0000_00DE);
        do_access(1'b0, BASE + 32'h12, 32'h0, 3'b001, "lh", rd, er);
        check("lh/lit", rd, 32'hFFFF_DEAD);

        // Response back-pressure: held response stays stable, new request waits.
        resp_ready = 1'b0;
        e1 = ref_access(1'b0, BASE + 32'h10, 32'h0, 3'b010);
        req_wen = 1'b0; req_addr = BASE + 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        stall_data = resp_rdata;
        check("stall/data", stall_data, e1[31:0]);
        e2 = ref_access(1'b0, BASE + 32'h4, 32'h0, 3'b010);
        req_addr = BASE + 32'h4; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall/valid", 32'(resp_valid), 32'd1);
            check("stall/hold", resp_rdata, e1[31:0]);
            check("stall/req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("stall/released", 32'(resp_valid), 32'd0);
        check("stall/idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("stall/accepted", 32'(req_ready), 32'd0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("stall/second_valid", 32'(resp_valid), 32'd1);
        check("stall/second_data", resp_rdata, e2[31:0]);
        @(negedge clk);

        // Reset during WAIT drops a store (model is deliberately not updated).
        req_wen = 1'b1; req_addr = BASE + 32'h20; req_wdata = 32'h1234_5678;
        req_funct3 = 3'b010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst/req_ready", 32'(req_ready), 32'd1);
        check("midrst/resp_valid", 32'(resp_valid), 32'd0);
        check("midrst/rdata", resp_rdata, 32'd0);
        check("midrst/err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_access(1'b0, BASE + 32'h20, 32'h0, 3'b010, "midrst_old", rd, er);

        // Access checking (or wrap/alignment behaviour without it).
        word0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
        do_access(1'b0, BASE + 32'h2, 32'h0, 3'b010, "lw_mis", rd, er);
        if (CHK) begin
            check("lw_mis/err_lit", 32'(er), 32'd1);
            check("lw_mis/zero_lit", rd, 32'd0);
        end else begin
            check("lw_mis/err_lit", 32'(er), 32'd0);
            check("lw_mis/word0", rd, word0);
        end
        do_access(1'b1, 32'h7FFF_FFFC, 32'h0BAD_F00D, 3'b010, "sw_low", rd, er);
        do_access(1'b0, BASE + 32'hFFC, 32'h0, 3'b010, "lw_last", rd, er);
        check("lw_last/lit", rd, CHK ? 32'hA5A5_5A5A : 32'h0BAD_F00D);

        // Randomised accesses within the initialised window.
        for (int i = 0; i < 300; i++) begin
            do_access(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 63)), $urandom,
                      3'($urandom_range(0, 7)), "rand", rd, er);
        end

        // Single-cycle instance: back-to-back requests complete every 2 cycles.
        f_req_wen = 1'b1; f_req_addr = BASE + 32'h8; f_req_wdata = 32'hCAFE_0001;
        f_req_funct3 = 3'b010; f_req_valid = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_resp_valid === 1'b1) nvalid++;
            check("fast/pattern", 32'(f_resp_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("fast/count", 32'(nvalid), 32'd10);
        f_req_wen = 1'b0;
        @(negedge clk);
        f_req_valid = 1'b0;
        check("fast/load_valid", 32'(f_resp_valid), 32'd1);
        check("fast/load_data", f_resp_rdata, 32'hCAFE_0001);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
